// File: rtl/i2c_txn_arbiter_if.sv
// Client-side request/response bundle plus the I2C master command port.
// The arbiter sits on the slave modport; clients and the master model sit on master.
interface i2c_txn_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] req_slave_addr;
  logic [8*N_REQ-1:0] req_reg_addr;
  logic [8*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]   req_read_write;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [1:0]         rsp_status;
  logic [7:0]         rsp_rdata;
  logic               m_enable;
  logic [6:0]         m_slave_addr;
  logic [7:0]         m_reg_addr;
  logic [7:0]         m_data;
  logic               m_read_write;
  logic               m_busy;
  logic               m_done;
  logic               m_ack_err;
  logic [7:0]         m_rdata;

  modport slave (
    input  req, req_slave_addr, req_reg_addr, req_wdata, req_read_write,
           m_busy, m_done, m_ack_err, m_rdata,
    output gnt, done, rsp_status, rsp_rdata,
           m_enable, m_slave_addr, m_reg_addr, m_data, m_read_write
  );

  modport master (
    output req, req_slave_addr, req_reg_addr, req_wdata, req_read_write,
           m_busy, m_done, m_ack_err, m_rdata,
    input  gnt, done, rsp_status, rsp_rdata,
           m_enable, m_slave_addr, m_reg_addr, m_data, m_read_write
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C master among N_REQ clients, with NACK retry
// and a per-issue timeout. All outputs are registers or Moore decodes of state.
module i2c_txn_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 4096
) (
  input logic              clk,
  input logic              reset,
  i2c_txn_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, win_q, sel;
  logic             sel_vld;
  logic [2:0]       retry_q;
  logic [TW-1:0]    tmo_q;
  logic [N_REQ-1:0] gnt_q;
  logic [1:0]       status_q;
  logic [7:0]       rdata_q;
  logic [6:0]       sa_q;
  logic [7:0]       ra_q, wd_q;
  logic             rw_q;
  logic             tmo_hit, retry_ok;
  logic [IW:0]      sum;

  logic [6:0] sa_a [N_REQ];
  logic [7:0] ra_a [N_REQ];
  logic [7:0] wd_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign sa_a[i] = bus.req_slave_addr[7*i +: 7];
    assign ra_a[i] = bus.req_reg_addr[8*i +: 8];
    assign wd_a[i] = bus.req_wdata[8*i +: 8];
  end

  // Scan offsets high-to-low so the smallest offset from ptr wins.
  always_comb begin
    sel     = ptr_q;
    sel_vld = 1'b0;
    sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (bus.req[sum[IW-1:0]]) begin
        sel     = sum[IW-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  assign tmo_hit  = (tmo_q + 1'b1) == TW'(TIMEOUT);
  assign retry_ok = bus.m_ack_err && (retry_q < 3'(MAX_RETRY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A done seen while still waiting for busy is resolved like a normal done;
  // done beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (sel_vld) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY, WAIT_DONE: begin
        if (bus.m_done)                             state_d = retry_ok ? ISSUE : COMPLETE;
        else if (tmo_hit)                           state_d = COMPLETE;
        else if (state_q == WAIT_BUSY && bus.m_busy) state_d = WAIT_DONE;
      end
      COMPLETE:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.m_enable = (state_q == ISSUE);
    bus.done     = '0;
    if (state_q == COMPLETE) bus.done[win_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      sa_q     <= '0;
      ra_q     <= '0;
      wd_q     <= '0;
      rw_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sel_vld) begin
          win_q   <= sel;
          gnt_q   <= N_REQ'(1) << sel;
          sa_q    <= sa_a[sel];
          ra_q    <= ra_a[sel];
          wd_q    <= wd_a[sel];
          rw_q    <= bus.req_read_write[sel];
          retry_q <= '0;
          tmo_q   <= '0;
        end
        ISSUE: tmo_q <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          tmo_q <= tmo_q + 1'b1;
          if (bus.m_done) begin
            if (retry_ok) retry_q <= retry_q + 1'b1;
            else begin
              status_q <= bus.m_ack_err ? 2'b01 : 2'b00;
              rdata_q  <= (!bus.m_ack_err && rw_q) ? bus.m_rdata : 8'h00;
            end
          end else if (tmo_hit) begin
            status_q <= 2'b10;
            rdata_q  <= 8'h00;
          end
        end
        COMPLETE: begin
          gnt_q    <= '0;
          status_q <= '0;
          rdata_q  <= '0;
          ptr_q    <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rsp_status   = status_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.m_slave_addr = sa_q;
  assign bus.m_reg_addr   = ra_q;
  assign bus.m_data       = wd_q;
  assign bus.m_read_write = rw_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized batches of client requests against a queue-based reference:
// grant order, per-issue command, master responses and completion results.
module tb_i2c_txn_arbiter;
  localparam int N  = 4;
  localparam int MR = 2;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.N_REQ(N)) bus ();
  i2c_txn_arbiter #(.N_REQ(N), .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  typedef struct {
    int id; logic [6:0] sa; logic [7:0] ra; logic [7:0] wd; logic rw;
    logic ae; logic hang; logic skip; int bdly; int ddly; logic [7:0] rd;
  } att_t;
  typedef struct { int id; logic [1:0] st; logic [7:0] rd; logic tmo; } rsp_t;

  att_t att_q[$];
  rsp_t rsp_q[$];

  int checks = 0, fails = 0;
  int stall_cnt = 0, stall_seen = 0;
  bit sim_done = 1'b0;
  int ptr_m = 0;

  logic [6:0] f_sa [N];
  logic [7:0] f_ra [N], f_wd [N], f_rd [N];
  logic       f_rw [N];
  int         f_nn [N];
  bit         f_hang [N];

  function automatic att_t timing(input att_t a);
    att_t b = a;
    b.skip = ($urandom % 4) == 0;
    b.bdly = $urandom_range(1, 3);
    b.ddly = b.bdly + $urandom_range(0, 12);
    return b;
  endfunction

  // Expected outcome from the rules: nn NACKs, then a hang (timeout),
  // exhaustion (nn > MR) or a clean finish.
  task automatic plan(input int id, input bit push_rsp);
    att_t a; rsp_t r;
    a.id = id; a.sa = f_sa[id]; a.ra = f_ra[id]; a.wd = f_wd[id];
    a.rw = f_rw[id]; a.rd = f_rd[id]; a.hang = 1'b0; a.ae = 1'b1;
    for (int n = 0; n < f_nn[id]; n++) att_q.push_back(timing(a));
    a.ae = 1'b0; r.id = id; r.tmo = 1'b0; r.rd = 8'h00;
    if (f_hang[id]) begin
      a.hang = 1'b1; att_q.push_back(timing(a)); r.st = 2'b10; r.tmo = 1'b1;
    end else if (f_nn[id] > MR) begin
      r.st = 2'b01;
    end else begin
      att_q.push_back(timing(a)); r.st = 2'b00; r.rd = f_rw[id] ? f_rd[id] : 8'h00;
    end
    if (push_rsp) rsp_q.push_back(r);
  endtask

  task automatic rand_fields(input int id);
    f_sa[id] = 7'($urandom); f_ra[id] = 8'($urandom); f_wd[id] = 8'($urandom);
    f_rw[id] = 1'($urandom); f_rd[id] = 8'($urandom);
    f_nn[id] = $urandom_range(0, MR + 1);
    f_hang[id] = ($urandom % 8) == 0;
    if (f_hang[id] && f_nn[id] > MR) f_nn[id] = MR;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_slave_addr[7*i +: 7] = f_sa[i];
      bus.req_reg_addr[8*i +: 8]   = f_ra[i];
      bus.req_wdata[8*i +: 8]      = f_wd[i];
      bus.req_read_write[i]        = f_rw[i];
    end
  endtask

  task automatic run_batch(input logic [N-1:0] pend);
    int last = 0; int budget = 0; int id;
    for (int k = 0; k < N; k++) begin
      id = (ptr_m + k) % N;
      if (pend[id]) begin plan(id, 1'b1); last = id; end
    end
    ptr_m = (last + 1) % N;
    drive_fields();
    bus.req = pend;
    while (bus.req != '0 && budget < 3000) begin
      @(negedge clk);
      budget++;
      bus.req = bus.req & ~bus.done;
      // Fields of a granted client must no longer matter.
      for (int i = 0; i < N; i++) if (bus.gnt[i]) begin
        bus.req_slave_addr[7*i +: 7] = 7'($urandom);
        bus.req_reg_addr[8*i +: 8]   = 8'($urandom);
        bus.req_wdata[8*i +: 8]      = 8'($urandom);
        bus.req_read_write[i]        = 1'($urandom);
      end
    end
    if (bus.req != '0) stall_cnt++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w; int budget;
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      f_sa[i] = '0; f_ra[i] = '0; f_wd[i] = '0; f_rw[i] = 1'b0;
      f_rd[i] = '0; f_nn[i] = 0; f_hang[i] = 1'b0;
    end
    drive_fields();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    f_sa[1] = 7'h50; f_ra[1] = 8'h10; f_wd[1] = 8'hA5; f_rw[1] = 1'b0; f_rd[1] = 8'h77;
    run_batch(4'b0010);
    f_sa[2] = 7'h21; f_ra[2] = 8'h04; f_rw[2] = 1'b1; f_rd[2] = 8'h3C;
    run_batch(4'b0100);
    f_nn[0] = 3; f_rw[0] = 1'b1; f_rd[0] = 8'hEE;
    f_nn[3] = 1; f_rw[3] = 1'b1; f_rd[3] = 8'h5A;
    run_batch(4'b1001);
    f_nn[1] = 0; f_hang[1] = 1'b1;
    run_batch(4'b0010);
    repeat (40) begin
      for (int i = 0; i < N; i++) rand_fields(i);
      run_batch(4'($urandom_range(1, 15)));
    end
    // Reset while the first of {0,3} is in WAIT_DONE; afterwards 0 must win.
    for (int i = 0; i < N; i++) begin rand_fields(i); f_nn[i] = 0; f_hang[i] = 1'b0; end
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && (((ptr_m + k) % N) == 0 || ((ptr_m + k) % N) == 3)) w = (ptr_m + k) % N;
    f_hang[w] = 1'b1; plan(w, 1'b0); f_hang[w] = 1'b0;
    drive_fields();
    bus.req = 4'b1001;
    budget = 0;
    while (!(bus.m_busy && bus.gnt != '0) && budget < 100) begin @(negedge clk); budget++; end
    if (budget >= 100) stall_cnt++;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    ptr_m = 0;
    run_batch(4'b1001);
    repeat (3) @(negedge clk);
    sim_done = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Master model + monitor; the only process that touches the counters.
  int   cyc = 0, last_en = 0, t = 0;
  bit   act = 1'b0;
  att_t cur;
  rsp_t r;

  always @(negedge clk) begin
    cyc++;
    bus.m_done    = 1'b0;
    bus.m_ack_err = 1'b0;
    bus.m_rdata   = 8'($urandom);
    if (stall_cnt != stall_seen) begin
      chk("wait_budget", 32'(stall_cnt), 32'(stall_seen));
      stall_seen = stall_cnt;
    end
    if (!rst_n) begin
      act = 1'b0; bus.m_busy = 1'b0;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_enable", 32'(bus.m_enable), 0);
      chk("rst_rsp", {22'd0, bus.rsp_status, bus.rsp_rdata}, 0);
      chk("rst_cmd", {8'd0, bus.m_slave_addr, bus.m_reg_addr, bus.m_data, bus.m_read_write}, 0);
    end else begin
      chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
      if (bus.m_enable) begin
        if (att_q.size() == 0) begin
          chk("unexpected_enable", 1, 0);
          act = 1'b0;
        end else begin
          cur = att_q.pop_front();
          chk("enable_gnt", 32'(bus.gnt), 32'(1 << cur.id));
          chk("enable_cmd", {8'd0, bus.m_slave_addr, bus.m_reg_addr, bus.m_data, bus.m_read_write},
                            {8'd0, cur.sa, cur.ra, cur.wd, cur.rw});
          act = 1'b1;
        end
        last_en = cyc; t = 0; bus.m_busy = 1'b0;
      end else if (act) begin
        t++;
        if (!cur.skip && t >= cur.bdly) bus.m_busy = 1'b1;
        if (!cur.hang && t == cur.ddly) begin
          bus.m_done = 1'b1; bus.m_ack_err = cur.ae; bus.m_rdata = cur.rd;
          bus.m_busy = 1'b0; act = 1'b0;
        end
      end
      if (bus.done != '0) begin
        if (rsp_q.size() == 0) chk("unexpected_done", 32'(bus.done), 0);
        else begin
          r = rsp_q.pop_front();
          chk("done_id", 32'(bus.done), 32'(1 << r.id));
          chk("done_status", 32'(bus.rsp_status), 32'(r.st));
          chk("done_rdata", 32'(bus.rsp_rdata), 32'(r.rd));
          if (r.tmo) chk("timeout_latency", 32'(cyc - last_en), TO + 1);
        end
      end
    end
    if (sim_done || cyc > 60000) begin
      chk("sim_cycle_budget", 32'(cyc > 60000), 0);
      chk("att_q_empty", 32'(att_q.size()), 0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end
  end
endmodule
